// File: rtl/axi_mm_master_arb2.sv
// axi_mm_master_arb2: merges two upstream AXI masters (m0, m1) onto a single
// downstream AXI master port (user_*).
//
// AR and AW each have an IDLE/BUSY arbiter. The downstream ID is
// {master index, upstream ID}, so R and B responses route back by ID bit 3.
// Each granted AW pushes its master index into a write-order FIFO. The head
// of that FIFO picks which master's W beats go downstream. A W beat with
// wlast pops the head.
//
// Optional build macro AXI_MM_ARB_FIXED_PRIO_EN: when defined, both
// arbiters use fixed priority (m0 wins ties). When undefined, they use
// round-robin, and m0 has priority out of reset.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. A downstream valid never depends on the same channel's
// downstream ready. Once raised, it holds until the handshake.
//
// While rst_wr is 1, every upstream ready and downstream valid is forced
// low, so nothing can hand off in the reset cycle.

module axi_mm_master_arb2 #(
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  // m0 AR
  input  logic [2:0]                    m0_arid,
  input  logic [2:0]                    m0_arsize,
  input  logic [7:0]                    m0_arlen,
  input  logic [1:0]                    m0_arburst,
  input  logic [31:0]                   m0_araddr,
  input  logic                          m0_arvalid,
  output logic                          m0_arready,
  // m0 AW
  input  logic [2:0]                    m0_awid,
  input  logic [2:0]                    m0_awsize,
  input  logic [7:0]                    m0_awlen,
  input  logic [1:0]                    m0_awburst,
  input  logic [31:0]                   m0_awaddr,
  input  logic                          m0_awvalid,
  output logic                          m0_awready,
  // m0 W
  input  logic [2:0]                    m0_wid,
  input  logic [63:0]                   m0_wdata,
  input  logic [7:0]                    m0_wstrb,
  input  logic                          m0_wlast,
  input  logic                          m0_wvalid,
  output logic                          m0_wready,
  // m0 R
  output logic [2:0]                    m0_rid,
  output logic [63:0]                   m0_rdata,
  output logic                          m0_rlast,
  output logic [1:0]                    m0_rresp,
  output logic                          m0_rvalid,
  input  logic                          m0_rready,
  // m0 B
  output logic [2:0]                    m0_bid,
  output logic [1:0]                    m0_bresp,
  output logic                          m0_bvalid,
  input  logic                          m0_bready,
  // m1 AR
  input  logic [2:0]                    m1_arid,
  input  logic [2:0]                    m1_arsize,
  input  logic [7:0]                    m1_arlen,
  input  logic [1:0]                    m1_arburst,
  input  logic [31:0]                   m1_araddr,
  input  logic                          m1_arvalid,
  output logic                          m1_arready,
  // m1 AW
  input  logic [2:0]                    m1_awid,
  input  logic [2:0]                    m1_awsize,
  input  logic [7:0]                    m1_awlen,
  input  logic [1:0]                    m1_awburst,
  input  logic [31:0]                   m1_awaddr,
  input  logic                          m1_awvalid,
  output logic                          m1_awready,
  // m1 W
  input  logic [2:0]                    m1_wid,
  input  logic [63:0]                   m1_wdata,
  input  logic [7:0]                    m1_wstrb,
  input  logic                          m1_wlast,
  input  logic                          m1_wvalid,
  output logic                          m1_wready,
  // m1 R
  output logic [2:0]                    m1_rid,
  output logic [63:0]                   m1_rdata,
  output logic                          m1_rlast,
  output logic [1:0]                    m1_rresp,
  output logic                          m1_rvalid,
  input  logic                          m1_rready,
  // m1 B
  output logic [2:0]                    m1_bid,
  output logic [1:0]                    m1_bresp,
  output logic                          m1_bvalid,
  input  logic                          m1_bready,
  // downstream AR
  output logic [3:0]                    user_arid,
  output logic [2:0]                    user_arsize,
  output logic [7:0]                    user_arlen,
  output logic [1:0]                    user_arburst,
  output logic [31:0]                   user_araddr,
  output logic                          user_arvalid,
  input  logic                          user_arready,
  // downstream AW
  output logic [3:0]                    user_awid,
  output logic [2:0]                    user_awsize,
  output logic [7:0]                    user_awlen,
  output logic [1:0]                    user_awburst,
  output logic [31:0]                   user_awaddr,
  output logic                          user_awvalid,
  input  logic                          user_awready,
  // downstream W
  output logic [3:0]                    user_wid,
  output logic [63:0]                   user_wdata,
  output logic [7:0]                    user_wstrb,
  output logic                          user_wlast,
  output logic                          user_wvalid,
  input  logic                          user_wready,
  // downstream R
  input  logic [3:0]                    user_rid,
  input  logic [63:0]                   user_rdata,
  input  logic                          user_rlast,
  input  logic [1:0]                    user_rresp,
  input  logic                          user_rvalid,
  output logic                          user_rready,
  // downstream B
  input  logic [3:0]                    user_bid,
  input  logic [1:0]                    user_bresp,
  input  logic                          user_bvalid,
  output logic                          user_bready,
  // debug visibility of internal state
  output logic                          o_ar_state,
  output logic                          o_aw_state,
  output logic [$clog2(WFIFO_DEPTH):0]  o_wfifo_count
);

  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WFIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // ---------------------------------------------------------------- AR
  logic [0:0] r_ar_state;
  logic       r_ar_gnt;
  logic       w_ar_req;
  logic       w_ar_pick;
  logic       w_ar_busy;

  assign w_ar_req  = m0_arvalid | m1_arvalid;
  assign w_ar_busy = (r_ar_state == ST_BUSY) && !rst_wr;

`ifdef AXI_MM_ARB_FIXED_PRIO_EN
  assign w_ar_pick = ~m0_arvalid;
`else
  logic r_ar_last;
  assign w_ar_pick = (m0_arvalid && m1_arvalid) ? ~r_ar_last : ~m0_arvalid;

  // Remember the last AR winner so that a tie goes to the other master.
  always_ff @(posedge clk_wr) begin
    if (rst_wr)
      r_ar_last <= 1'b1;
    else if (r_ar_state == ST_IDLE && w_ar_req)
      r_ar_last <= w_ar_pick;
  end
`endif

  // AR arbiter: grant in IDLE, hold the winner in BUSY until the handshake.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_ar_state <= ST_IDLE;
      r_ar_gnt   <= 1'b0;
    end else begin
      case (r_ar_state)
        ST_IDLE: if (w_ar_req) begin
          r_ar_state <= ST_BUSY;
          r_ar_gnt   <= w_ar_pick;
        end
        default: if (user_arready) r_ar_state <= ST_IDLE;
      endcase
    end
  end

  assign user_arvalid = w_ar_busy;
  assign user_arid    = {r_ar_gnt, r_ar_gnt ? m1_arid : m0_arid};
  assign user_arsize  = r_ar_gnt ? m1_arsize  : m0_arsize;
  assign user_arlen   = r_ar_gnt ? m1_arlen   : m0_arlen;
  assign user_arburst = r_ar_gnt ? m1_arburst : m0_arburst;
  assign user_araddr  = r_ar_gnt ? m1_araddr  : m0_araddr;
  assign m0_arready   = w_ar_busy && !r_ar_gnt && user_arready;
  assign m1_arready   = w_ar_busy &&  r_ar_gnt && user_arready;

  // ---------------------------------------------------------------- write-order FIFO signals
  logic [WFIFO_DEPTH-1:0] r_fifo;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW:0]            r_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // ---------------------------------------------------------------- AW
  logic [0:0] r_aw_state;
  logic       r_aw_gnt;
  logic       w_aw_req;
  logic       w_aw_pick;
  logic       w_aw_busy;

  assign w_aw_req  = m0_awvalid | m1_awvalid;
  assign w_aw_busy = (r_aw_state == ST_BUSY) && !rst_wr;

`ifdef AXI_MM_ARB_FIXED_PRIO_EN
  assign w_aw_pick = ~m0_awvalid;
`else
  logic r_aw_last;
  assign w_aw_pick = (m0_awvalid && m1_awvalid) ? ~r_aw_last : ~m0_awvalid;

  // Remember the last AW winner so that a tie goes to the other master.
  always_ff @(posedge clk_wr) begin
    if (rst_wr)
      r_aw_last <= 1'b1;
    else if (r_aw_state == ST_IDLE && w_aw_req && !w_full)
      r_aw_last <= w_aw_pick;
  end
`endif

  // AW arbiter: like AR, but it does not grant while the order FIFO is full.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_aw_state <= ST_IDLE;
      r_aw_gnt   <= 1'b0;
    end else begin
      case (r_aw_state)
        ST_IDLE: if (w_aw_req && !w_full) begin
          r_aw_state <= ST_BUSY;
          r_aw_gnt   <= w_aw_pick;
        end
        default: if (user_awready) r_aw_state <= ST_IDLE;
      endcase
    end
  end

  assign user_awvalid = w_aw_busy;
  assign user_awid    = {r_aw_gnt, r_aw_gnt ? m1_awid : m0_awid};
  assign user_awsize  = r_aw_gnt ? m1_awsize  : m0_awsize;
  assign user_awlen   = r_aw_gnt ? m1_awlen   : m0_awlen;
  assign user_awburst = r_aw_gnt ? m1_awburst : m0_awburst;
  assign user_awaddr  = r_aw_gnt ? m1_awaddr  : m0_awaddr;
  assign m0_awready   = w_aw_busy && !r_aw_gnt && user_awready;
  assign m1_awready   = w_aw_busy &&  r_aw_gnt && user_awready;

  // ---------------------------------------------------------------- FIFO
  // Only one AW is in flight, and it was granted with room to spare.
  // Likewise, a pop needs a non-empty head. So neither pointer overruns.
  assign w_push = user_awvalid && user_awready;
  assign w_pop  = user_wvalid && user_wready && user_wlast;

  // Write-order FIFO: push the AW winner, pop on the last W beat.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_fifo   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_aw_gnt;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- W routing
  logic w_wvalid_sel;
  assign w_wvalid_sel = w_head ? m1_wvalid : m0_wvalid;
  assign user_wvalid  = !rst_wr && !w_empty && w_wvalid_sel;
  assign user_wid     = {w_head, w_head ? m1_wid : m0_wid};
  assign user_wdata   = w_head ? m1_wdata : m0_wdata;
  assign user_wstrb   = w_head ? m1_wstrb : m0_wstrb;
  assign user_wlast   = w_head ? m1_wlast : m0_wlast;
  assign m0_wready    = !rst_wr && !w_empty && !w_head && user_wready;
  assign m1_wready    = !rst_wr && !w_empty &&  w_head && user_wready;

  // ---------------------------------------------------------------- R/B routing
  assign m0_rid      = user_rid[2:0];
  assign m1_rid      = user_rid[2:0];
  assign m0_rdata    = user_rdata;
  assign m1_rdata    = user_rdata;
  assign m0_rlast    = user_rlast;
  assign m1_rlast    = user_rlast;
  assign m0_rresp    = user_rresp;
  assign m1_rresp    = user_rresp;
  assign m0_rvalid   = user_rvalid && !user_rid[3];
  assign m1_rvalid   = user_rvalid &&  user_rid[3];
  assign user_rready = user_rid[3] ? m1_rready : m0_rready;

  assign m0_bid      = user_bid[2:0];
  assign m1_bid      = user_bid[2:0];
  assign m0_bresp    = user_bresp;
  assign m1_bresp    = user_bresp;
  assign m0_bvalid   = user_bvalid && !user_bid[3];
  assign m1_bvalid   = user_bvalid &&  user_bid[3];
  assign user_bready = user_bid[3] ? m1_bready : m0_bready;

  // ---------------------------------------------------------------- debug
  assign o_ar_state    = r_ar_state;
  assign o_aw_state    = r_aw_state;
  assign o_wfifo_count = r_count;

endmodule

// File: tb/tb_axi_mm_master_arb2.sv
// Directed self-checking bench for axi_mm_master_arb2 (WFIFO_DEPTH = 4).
// Inputs are driven 1 ns after each rising edge. Outputs are sampled a few
// ns later, well before the next edge.
module tb_axi_mm_master_arb2;

  logic clk_wr = 1'b0;
  logic rst_wr;

  logic [2:0]  m0_arid, m0_arsize, m1_arid, m1_arsize;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [1:0]  m0_arburst, m1_arburst;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [2:0]  m0_awid, m0_awsize, m1_awid, m1_awsize;
  logic [7:0]  m0_awlen, m1_awlen;
  logic [1:0]  m0_awburst, m1_awburst;
  logic [31:0] m0_awaddr, m1_awaddr;
  logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [2:0]  m0_wid, m1_wid;
  logic [63:0] m0_wdata, m1_wdata;
  logic [7:0]  m0_wstrb, m1_wstrb;
  logic        m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic [2:0]  m0_rid, m1_rid;
  logic [63:0] m0_rdata, m1_rdata;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [1:0]  m0_rresp, m1_rresp;
  logic [2:0]  m0_bid, m1_bid;
  logic [1:0]  m0_bresp, m1_bresp;
  logic        m0_bvalid, m1_bvalid, m0_bready, m1_bready;

  logic [3:0]  user_arid, user_awid, user_wid, user_rid, user_bid;
  logic [2:0]  user_arsize, user_awsize;
  logic [7:0]  user_arlen, user_awlen, user_wstrb;
  logic [1:0]  user_arburst, user_awburst, user_rresp, user_bresp;
  logic [31:0] user_araddr, user_awaddr;
  logic [63:0] user_wdata, user_rdata;
  logic        user_arvalid, user_arready, user_awvalid, user_awready;
  logic        user_wlast, user_wvalid, user_wready;
  logic        user_rlast, user_rvalid, user_rready, user_bvalid, user_bready;
  logic        o_ar_state, o_aw_state;
  logic [2:0]  o_wfifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  axi_mm_master_arb2 #(.WFIFO_DEPTH(4)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr),
    .m0_arid(m0_arid), .m0_arsize(m0_arsize), .m0_arlen(m0_arlen), .m0_arburst(m0_arburst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_awid(m0_awid), .m0_awsize(m0_awsize), .m0_awlen(m0_awlen), .m0_awburst(m0_awburst),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wid(m0_wid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rresp(m0_rresp),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_arid(m1_arid), .m1_arsize(m1_arsize), .m1_arlen(m1_arlen), .m1_arburst(m1_arburst),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_awid(m1_awid), .m1_awsize(m1_awsize), .m1_awlen(m1_awlen), .m1_awburst(m1_awburst),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wid(m1_wid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rresp(m1_rresp),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
    .user_arburst(user_arburst), .user_araddr(user_araddr), .user_arvalid(user_arvalid),
    .user_arready(user_arready),
    .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
    .user_awburst(user_awburst), .user_awaddr(user_awaddr), .user_awvalid(user_awvalid),
    .user_awready(user_awready),
    .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
    .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
    .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
    .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
    .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
    .user_bready(user_bready),
    .o_ar_state(o_ar_state), .o_aw_state(o_aw_state), .o_wfifo_count(o_wfifo_count)
  );

  // clock
  always #5 clk_wr = ~clk_wr;

  // advance to 1 ns after the next rising edge
  task cyc;
    @(posedge clk_wr); #1;
  endtask

  task drive_idle;
    m0_arid = '0; m0_arsize = 3'd3; m0_arlen = '0; m0_arburst = 2'b01; m0_araddr = '0; m0_arvalid = 0;
    m1_arid = '0; m1_arsize = 3'd3; m1_arlen = '0; m1_arburst = 2'b01; m1_araddr = '0; m1_arvalid = 0;
    m0_awid = '0; m0_awsize = 3'd3; m0_awlen = '0; m0_awburst = 2'b01; m0_awaddr = '0; m0_awvalid = 0;
    m1_awid = '0; m1_awsize = 3'd3; m1_awlen = '0; m1_awburst = 2'b01; m1_awaddr = '0; m1_awvalid = 0;
    m0_wid = '0; m0_wdata = '0; m0_wstrb = 8'hFF; m0_wlast = 0; m0_wvalid = 0;
    m1_wid = '0; m1_wdata = '0; m1_wstrb = 8'hFF; m1_wlast = 0; m1_wvalid = 0;
    m0_rready = 0; m1_rready = 0; m0_bready = 0; m1_bready = 0;
    user_arready = 0; user_awready = 0; user_wready = 0;
    user_rid = '0; user_rdata = '0; user_rlast = 0; user_rresp = '0; user_rvalid = 0;
    user_bid = '0; user_bresp = '0; user_bvalid = 0;
  endtask

  task test_reset;
    rst_wr = 1;
    m0_arvalid = 1; m1_awvalid = 1; m0_wvalid = 1; user_wready = 1; user_arready = 1;
    cyc; cyc; #2;
    n_checks++; if (user_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %b exp 0", user_arvalid); end
    n_checks++; if (user_awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid got %b exp 0", user_awvalid); end
    n_checks++; if (user_wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid got %b exp 0", user_wvalid); end
    n_checks++; if ({m0_arready, m1_arready, m0_awready, m1_awready, m0_wready, m1_wready} !== 6'b0) begin
      n_fail++; $display("FAIL rst_readys got %b exp 000000", {m0_arready, m1_arready, m0_awready, m1_awready, m0_wready, m1_wready}); end
    n_checks++; if (o_wfifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", o_wfifo_count); end
    cyc;
    drive_idle; rst_wr = 0; #2;
    n_checks++; if ({user_arvalid, o_ar_state, o_aw_state} !== 3'b000) begin
      n_fail++; $display("FAIL post_rst_idle got %b exp 000", {user_arvalid, o_ar_state, o_aw_state}); end
    cyc;
  endtask

  task test_ar_arbitration;
    logic [3:0] exp_id;
    m0_arid = 3'h5; m0_araddr = 32'h0000_1000; m0_arlen = 8'h07;
    m1_arid = 3'h6; m1_araddr = 32'h0000_2000; m1_arlen = 8'h03;
    user_arready = 1; m0_arvalid = 1; m1_arvalid = 1; #2;
    n_checks++; if (user_arvalid !== 1'b0) begin n_fail++; $display("FAIL ar_latency got %b exp 0", user_arvalid); end
    cyc; #2;
    n_checks++; if ({user_arvalid, user_arid} !== {1'b1, 4'h5}) begin
      n_fail++; $display("FAIL ar_first_grant got v=%b id=%h exp v=1 id=5", user_arvalid, user_arid); end
    n_checks++; if ({user_araddr, user_arlen} !== {32'h0000_1000, 8'h07}) begin
      n_fail++; $display("FAIL ar_first_fields got %h/%h exp 00001000/07", user_araddr, user_arlen); end
    n_checks++; if ({m0_arready, m1_arready} !== 2'b10) begin
      n_fail++; $display("FAIL ar_first_ready got %b exp 10", {m0_arready, m1_arready}); end
    cyc;
`ifndef AXI_MM_ARB_FIXED_PRIO_EN
    m0_arvalid = 0;
`endif
    #2;
    n_checks++; if (user_arvalid !== 1'b0) begin n_fail++; $display("FAIL ar_gap got %b exp 0", user_arvalid); end
    cyc; #2;
`ifdef AXI_MM_ARB_FIXED_PRIO_EN
    exp_id = 4'h5;
`else
    exp_id = 4'hE;
`endif
    n_checks++; if ({user_arvalid, user_arid} !== {1'b1, exp_id}) begin
      n_fail++; $display("FAIL ar_second_grant got v=%b id=%h exp v=1 id=%h", user_arvalid, user_arid, exp_id); end
    n_checks++; if ({m0_arready, m1_arready} !== {~exp_id[3], exp_id[3]}) begin
      n_fail++; $display("FAIL ar_second_ready got %b exp %b", {m0_arready, m1_arready}, {~exp_id[3], exp_id[3]}); end
    cyc;
    m0_arvalid = 0; m1_arvalid = 0;
    cyc;
    // m0 alone, then a tie: round-robin now favours m1
    m0_arvalid = 1;
    cyc; cyc;
    m1_arvalid = 1;
    cyc; #2;
`ifdef AXI_MM_ARB_FIXED_PRIO_EN
    exp_id = 4'h5;
`else
    exp_id = 4'hE;
`endif
    n_checks++; if ({user_arvalid, user_arid} !== {1'b1, exp_id}) begin
      n_fail++; $display("FAIL ar_rr_tie got v=%b id=%h exp v=1 id=%h", user_arvalid, user_arid, exp_id); end
    cyc;
    m0_arvalid = 0; m1_arvalid = 0;
    cyc;
  endtask

  task test_w_order;
    m1_awid = 3'h1; m1_awlen = 8'd3; m0_awid = 3'h2; m0_awlen = 8'd0;
    m1_wid = 3'h1; m0_wid = 3'h2; m0_wdata = 64'hAAAA_0000_0000_0001; m0_wlast = 1;
    user_awready = 1; user_wready = 1;
    m1_awvalid = 1; m0_wvalid = 1; m1_wvalid = 1; m1_wdata = 64'h1000; m1_wlast = 0; #2;
    n_checks++; if ({user_wvalid, m0_wready, m1_wready} !== 3'b000) begin
      n_fail++; $display("FAIL w_empty_stall got %b exp 000", {user_wvalid, m0_wready, m1_wready}); end
    cyc; #2;
    n_checks++; if ({user_awvalid, user_awid, user_awlen} !== {1'b1, 4'h9, 8'd3}) begin
      n_fail++; $display("FAIL aw_m1_grant got v=%b id=%h len=%0d exp v=1 id=9 len=3", user_awvalid, user_awid, user_awlen); end
    n_checks++; if (user_wvalid !== 1'b0) begin n_fail++; $display("FAIL w_before_aw got %b exp 0", user_wvalid); end
    cyc;
    m1_awvalid = 0;
    for (int b = 0; b < 4; b++) begin
      m1_wdata = 64'h1000 + 64'(b); m1_wlast = (b == 3);
      if (b == 0) m0_awvalid = 1;
      if (b == 2) m0_awvalid = 0;
      #2;
      n_checks++; if ({user_wvalid, user_wid, user_wlast} !== {1'b1, 4'h9, (b == 3)}) begin
        n_fail++; $display("FAIL w_m1_beat%0d got v=%b id=%h last=%b", b, user_wvalid, user_wid, user_wlast); end
      n_checks++; if (user_wdata !== 64'h1000 + 64'(b)) begin
        n_fail++; $display("FAIL w_m1_data%0d got %h exp %h", b, user_wdata, 64'h1000 + 64'(b)); end
      n_checks++; if ({m0_wready, m1_wready} !== 2'b01) begin
        n_fail++; $display("FAIL w_m1_ready%0d got %b exp 01", b, {m0_wready, m1_wready}); end
      if (b == 1) begin
        n_checks++; if ({user_awvalid, user_awid} !== {1'b1, 4'h2}) begin
          n_fail++; $display("FAIL aw_m0_grant got v=%b id=%h exp v=1 id=2", user_awvalid, user_awid); end
      end
      cyc;
    end
    m1_wvalid = 0; #2;
    n_checks++; if ({user_wvalid, user_wid, user_wlast} !== {1'b1, 4'h2, 1'b1}) begin
      n_fail++; $display("FAIL w_m0_beat got v=%b id=%h last=%b exp 1/2/1", user_wvalid, user_wid, user_wlast); end
    n_checks++; if (user_wdata !== 64'hAAAA_0000_0000_0001) begin
      n_fail++; $display("FAIL w_m0_data got %h exp aaaa000000000001", user_wdata); end
    n_checks++; if ({m0_wready, m1_wready, o_wfifo_count} !== {2'b10, 3'd1}) begin
      n_fail++; $display("FAIL w_m0_ready got %b cnt=%0d exp 10 cnt=1", {m0_wready, m1_wready}, o_wfifo_count); end
    cyc;
    m0_wvalid = 0; #2;
    n_checks++; if ({user_wvalid, o_wfifo_count} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL w_drained got v=%b cnt=%0d exp 0/0", user_wvalid, o_wfifo_count); end
    user_wready = 0; m0_wlast = 0;
    cyc;
  endtask

  task test_wfifo_full;
    user_awready = 1; user_wready = 0; m0_awid = 3'h3; m0_wid = 3'h3; m0_awvalid = 1;
    repeat (8) cyc;
    #2;
    n_checks++; if ({user_awvalid, o_wfifo_count} !== {1'b0, 3'd4}) begin
      n_fail++; $display("FAIL full_block got v=%b cnt=%0d exp 0/4", user_awvalid, o_wfifo_count); end
    cyc; #2;
    n_checks++; if ({user_awvalid, m0_awready} !== 2'b00) begin
      n_fail++; $display("FAIL full_hold got %b exp 00", {user_awvalid, m0_awready}); end
    m0_wvalid = 1; m0_wlast = 1; user_wready = 1; #1;
    n_checks++; if ({user_wvalid, user_wid} !== {1'b1, 4'h3}) begin
      n_fail++; $display("FAIL full_wbeat got v=%b id=%h exp 1/3", user_wvalid, user_wid); end
    cyc;
    m0_wvalid = 0; user_wready = 0; #2;
    n_checks++; if (o_wfifo_count !== 3'd3) begin n_fail++; $display("FAIL full_pop got %0d exp 3", o_wfifo_count); end
    cyc; #2;
    n_checks++; if ({user_awvalid, user_awid} !== {1'b1, 4'h3}) begin
      n_fail++; $display("FAIL full_regrant got v=%b id=%h exp 1/3", user_awvalid, user_awid); end
    cyc;
    m0_awvalid = 0; #2;
    n_checks++; if (o_wfifo_count !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d exp 4", o_wfifo_count); end
    m0_wvalid = 1; user_wready = 1;
    repeat (4) cyc;
    m0_wvalid = 0; user_wready = 0; m0_wlast = 0; #2;
    n_checks++; if (o_wfifo_count !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d exp 0", o_wfifo_count); end
    cyc;
  endtask

  task test_rb_route;
    user_rvalid = 1; user_rid = 4'hA; user_rdata = 64'hDEAD_BEEF_0123_4567; user_rlast = 1; user_rresp = 2'b10;
    m0_rready = 1; m1_rready = 0; #2;
    n_checks++; if ({m1_rvalid, m1_rid, m0_rvalid, user_rready} !== {1'b1, 3'h2, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL r_to_m1 got m1v=%b m1id=%h m0v=%b rr=%b exp 1/2/0/0", m1_rvalid, m1_rid, m0_rvalid, user_rready); end
    n_checks++; if ({m0_rdata, m0_rlast, m1_rresp} !== {64'hDEAD_BEEF_0123_4567, 1'b1, 2'b10}) begin
      n_fail++; $display("FAIL r_broadcast got %h/%b/%b", m0_rdata, m0_rlast, m1_rresp); end
    m1_rready = 1; #1;
    n_checks++; if (user_rready !== 1'b1) begin n_fail++; $display("FAIL r_m1_ready got %b exp 1", user_rready); end
    user_rid = 4'h3; m1_rready = 0; #1;
    n_checks++; if ({m0_rvalid, m0_rid, m1_rvalid, user_rready} !== {1'b1, 3'h3, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL r_to_m0 got m0v=%b m0id=%h m1v=%b rr=%b exp 1/3/0/1", m0_rvalid, m0_rid, m1_rvalid, user_rready); end
    user_bvalid = 1; user_bid = 4'h3; user_bresp = 2'b01; m0_bready = 1; m1_bready = 0; #1;
    n_checks++; if ({m0_bvalid, m0_bid, m1_bvalid, user_bready, m1_bresp} !== {1'b1, 3'h3, 1'b0, 1'b1, 2'b01}) begin
      n_fail++; $display("FAIL b_to_m0 got m0v=%b id=%h m1v=%b br=%b resp=%b", m0_bvalid, m0_bid, m1_bvalid, user_bready, m1_bresp); end
    user_bid = 4'hC; #1;
    n_checks++; if ({m1_bvalid, m1_bid, m0_bvalid, user_bready} !== {1'b1, 3'h4, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL b_to_m1 got m1v=%b id=%h m0v=%b br=%b exp 1/4/0/0", m1_bvalid, m1_bid, m0_bvalid, user_bready); end
    user_rvalid = 0; user_bvalid = 0; m0_rready = 0; m0_bready = 0;
    cyc;
  endtask

  task test_reset_mid;
    user_awready = 1; m1_awid = 3'h5; m1_awvalid = 1;
    cyc; cyc;
    m1_awvalid = 0; #2;
    n_checks++; if (o_wfifo_count !== 3'd1) begin n_fail++; $display("FAIL mid_preload got %0d exp 1", o_wfifo_count); end
    user_arready = 0; m1_arid = 3'h7; m1_araddr = 32'h0000_3000; m1_arvalid = 1; m0_arid = 3'h4;
    cyc; #2;
    n_checks++; if ({user_arvalid, user_arid} !== {1'b1, 4'hF}) begin
      n_fail++; $display("FAIL mid_m1_grant got v=%b id=%h exp 1/f", user_arvalid, user_arid); end
    m0_arvalid = 1;
    cyc; #2;
    n_checks++; if ({user_arid, user_araddr, m0_arready, m1_arready} !== {4'hF, 32'h0000_3000, 2'b00}) begin
      n_fail++; $display("FAIL mid_hold got id=%h addr=%h rdy=%b exp f/00003000/00", user_arid, user_araddr, {m0_arready, m1_arready}); end
    rst_wr = 1; #2;
    n_checks++; if (user_arvalid !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset got %b exp 0", user_arvalid); end
    cyc;
    rst_wr = 0; #2;
    n_checks++; if ({user_arvalid, m0_arready, m1_arready, o_ar_state} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_after_reset got %b exp 0000", {user_arvalid, m0_arready, m1_arready, o_ar_state}); end
    n_checks++; if (o_wfifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_fifo_cleared got %0d exp 0", o_wfifo_count); end
    cyc; #2;
    n_checks++; if ({user_arvalid, user_arid} !== {1'b1, 4'h4}) begin
      n_fail++; $display("FAIL mid_m0_priority got v=%b id=%h exp 1/4", user_arvalid, user_arid); end
    user_arready = 1;
    cyc;
    m0_arvalid = 0; m1_arvalid = 0;
    cyc; cyc;
  endtask

  initial begin
    drive_idle;
    rst_wr = 1;
    test_reset;
    test_ar_arbitration;
    test_w_order;
    test_wfifo_full;
    test_rb_route;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
